// File: rtl/hilo_pkg.sv
// hilo_pkg
//   Shared definitions for the HI/LO multiply/divide unit:
//   operation encodings and the control FSM state type.
package hilo_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } hilo_state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if
//   Bundles the request, MT-write and result signals of the HI/LO unit.
//   master: the pipeline side (drives start/op/operands/mthi/mtlo/wdata)
//   slave : the HI/LO unit (drives busy/done/div_by_zero/hi_out/lo_out)
//
//   Handshake: a request is accepted on a rising edge where start=1 and
//   busy=0; start while busy=1 is dropped, never queued. done pulses for
//   exactly one cycle when the result has been written into HI/LO, and
//   div_by_zero is meaningful in that same cycle.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_iter_core.sv
// hilo_iter_core
//   Unsigned WIDTH-step iterative datapath.
//   Multiply: shift-add, {hi,lo} ends as the 2*WIDTH-bit product.
//   Divide  : restoring division, hi ends as remainder, lo as quotient.
// Ports:
//   clk, reset     clock, async active-high reset
//   load           capture a_mag/b_mag and clear the partial result
//   step           perform one iteration
//   is_div         selects divide (1) or multiply (0); held stable by caller
//   a_mag, b_mag   operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   hi_raw, lo_raw unsigned result halves
module hilo_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] hi_raw,
    output logic [WIDTH-1:0] lo_raw
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        // Multiply: add the multiplicand when the current multiplier bit
        // is set, then shift {carry,hi,lo} right by one.
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Divide: bring the next dividend bit into the partial remainder.
        // A clear borrow bit means the trial subtraction fits.
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (load) begin
            hi_d = '0;
            lo_d = a_mag;
            b_d  = b_mag;
        end else if (step) begin
            if (is_div) begin
                if (!diff[WIDTH]) begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi_raw = hi_q;
    assign lo_raw = lo_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Architectural HI/LO registers with an iterative MULT/MULTU/DIV/DIVU
//   engine and MTHI/MTLO writes.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   bus        hilo_muldiv_unit_if.slave (request, MT writes, results)
//   dbg_state  current control FSM state
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    hilo_muldiv_unit_if.slave       bus,
    output hilo_state_e             dbg_state
);

    hilo_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;     // result (product/quotient) is negative
    logic               sa_q, sa_d;       // dividend was negative
    logic               bz_q, bz_d;       // divisor was zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               signed_op, a_neg, b_neg, load, step;
    logic [WIDTH-1:0]   a_mag, b_mag, hi_raw, lo_raw, quot_s, rem_s;
    logic [2*WIDTH-1:0] prod_s;

    // Signed ops are the ones with op[0]==0 (MULT, DIV).
    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.src_a[WIDTH-1];
    assign b_neg     = signed_op & bus.src_b[WIDTH-1];
    assign a_mag     = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag     = b_neg ? -bus.src_b : bus.src_b;
    assign load      = (state_q == IDLE) && bus.start;
    assign step      = (state_q == RUN);

    hilo_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (is_div_q),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .hi_raw (hi_raw),
        .lo_raw (lo_raw)
    );

    // Remainder follows the dividend sign. With a zero divisor the core
    // leaves the dividend magnitude in hi, so rem_s reproduces src_a.
    assign prod_s = neg_q ? -{hi_raw, lo_raw} : {hi_raw, lo_raw};
    assign quot_s = neg_q ? -lo_raw : lo_raw;
    assign rem_s  = sa_q ? -hi_raw : hi_raw;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        bz_d     = bz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.mthi) hi_d = bus.wdata;
                if (bus.mtlo) lo_d = bus.wdata;
                if (bus.start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = bus.op[1];
                    neg_d    = a_neg ^ b_neg;
                    sa_d     = a_neg;
                    bz_d     = (bus.src_b == '0);
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                if (is_div_q) begin
                    hi_d = rem_s;
                    if (bz_q) begin
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = quot_s;
                    end
                end else begin
                    {hi_d, lo_d} = prod_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            bz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            bz_q     <= bz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    hilo_state_e dbg_state;

    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard entries: {div_by_zero, hi, lo}
    logic [2*W:0] exp_q[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        longint      sa, sb;
        logic [W-1:0] q, r;
        case (op)
            OP_MULT: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                return {1'b0, p};
            end
            OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            OP_DIV: begin
                if (b == 0) return {1'b1, a, {W{1'b1}}};
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {1'b0, r, q};
            end
            default: begin
                if (b == 0) return {1'b1, a, {W{1'b1}}};
                q = a / b;
                r = a % b;
                return {1'b0, r, q};
            end
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [2*W:0] e;
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = exp_q.pop_front();
                check("result_hi", bus.hi_out, e[2*W-1:W]);
                check("result_lo", bus.lo_out, e[W-1:0]);
                check("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e[2*W]});
                model_hi = e[2*W-1:W];
                model_lo = e[W-1:0];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        exp_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        // Scramble the operand inputs; they must not be re-read.
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.src_a = $urandom;
        bus.src_b = $urandom;
    endtask

    task automatic wait_idle(output int cyc, output bit held);
        cyc  = 0;
        held = 1'b1;
        while (cyc < 100) begin
            @(negedge clk);
            if (!bus.busy) break;
            cyc++;
            if (bus.hi_out !== model_hi || bus.lo_out !== model_lo) held = 1'b0;
        end
        if (cyc >= 100) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: got busy after %0d cycles expected idle", cyc);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int cyc;
        bit held;
        start_op(op, a, b);
        wait_idle(cyc, held);
        check("busy_cycles", cyc, W + 1);
        check("regs_held_in_run", {31'b0, held}, 32'd1);
        check("done_pulse", {31'b0, bus.done}, 32'd1);
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [W-1:0] d);
        @(negedge clk);
        bus.mthi  = h;
        bus.mtlo  = l;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (h) model_hi = d;
        if (l) model_lo = d;
        @(negedge clk);
        check("mt_hi", bus.hi_out, model_hi);
        check("mt_lo", bus.lo_out, model_lo);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int  cyc;
        bit  held;
        logic [1:0]   op;
        logic [W-1:0] a, b;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", bus.hi_out, '0);
        check("reset_lo", bus.lo_out, '0);
        check("reset_busy", {31'b0, bus.busy}, '0);
        check("reset_done", {31'b0, bus.done}, '0);
        check("reset_dbz", {31'b0, bus.div_by_zero}, '0);
        reset = 1'b0;

        // Directed cases
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(OP_MULT, -32'sd3, 32'sd5);
        run_op(OP_DIV, -32'sd7, 32'sd2);
        run_op(OP_DIVU, 32'd100, 32'd0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_DIV, -32'sd9, 32'd0);
        mt_write(1'b1, 1'b1, 32'h1234_5678);
        mt_write(1'b1, 1'b0, 32'hCAFE_0001);
        mt_write(1'b0, 1'b1, 32'hCAFE_0002);

        // MT write and second start while busy are both ignored
        start_op(OP_MULTU, 32'd2, 32'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        @(posedge clk);
        #1;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.start = 1'b0;
        wait_idle(cyc, held);
        check("busy_ignore_held", {31'b0, held}, 32'd1);
        check("busy_ignore_hi", bus.hi_out, 32'd0);
        check("busy_ignore_lo", bus.lo_out, 32'd6);
        repeat (40) @(negedge clk);

        // MT write accepted in the same cycle as start; commit overwrites
        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h0BAD_F00D;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.src_a = 32'd7;
        bus.src_b = 32'd11;
        exp_q.push_back(model(OP_MULTU, 32'd7, 32'd11));
        @(posedge clk);
        #1;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.start = 1'b0;
        model_hi  = 32'h0BAD_F00D;
        model_lo  = 32'h0BAD_F00D;
        check("same_cycle_mt_lo", bus.lo_out, 32'h0BAD_F00D);
        wait_idle(cyc, held);
        check("same_cycle_busy", cyc, W + 1);

        // Reset in the middle of a DIVU aborts with no commit
        start_op(OP_DIVU, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, '0);
        check("abort_hi", bus.hi_out, '0);
        check("abort_lo", bus.lo_out, '0);
        check("abort_done", {31'b0, bus.done}, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run_op(OP_DIVU, 32'd9, 32'd4);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op(op, a, b);
            if (i % 4 == 3) mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised HI/LO register unit with an integrated iterative multiply/divide engine for the MIPS datapath.
- Holds the architectural HI and LO registers and performs MULT, MULTU, DIV and DIVU over multiple cycles, committing the results to HI/LO.
- Services direct MTHI/MTLO writes.
- Read ports always show committed HI/LO. The pipeline stalls MFHI/MFLO on busy.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  request an operation; accepted only while busy=0
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
src_a  in  WIDTH  multiplicand / dividend; sampled with start
src_b  in  WIDTH  multiplier / divisor; sampled with start
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse when HI/LO are committed by an operation
div_by_zero  out  1  valid with done; set when a DIV/DIVU had src_b==0
hi_out  out  WIDTH  committed HI register
lo_out  out  WIDTH  committed LO register

Behaviour:
- Reset, asynchronous: hi_out=0, lo_out=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0. Reset mid-operation aborts the operation with no commit.
- States:
  - IDLE: start=1 latches op and the operand magnitudes (signed ops take abs; sign flags are kept). Transition to RUN, counter=0, busy=1.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After WIDTH steps, transition to FIX.
  - FIX: apply signs and commit HI/LO. Pulse done=1 and drop busy=0. Return to IDLE.
- Latency: start sampled at edge E0. Busy is high for WIDTH+1 cycles. Commit happens at edge E(WIDTH+1), with done high for the following cycle.
- Multiply result:
  - Full 2*WIDTH-bit product: HI = upper WIDTH bits, LO = lower WIDTH bits.
  - Signed product = two's-complement negation of the magnitude product when the operand signs differ.
- Divide result:
  - LO = quotient, truncated toward zero. HI = remainder, carrying the sign of the dividend.
  - Signed overflow (min_int / -1): LO = 1<<(WIDTH-1), HI = 0.
- Divide by zero: same latency. LO = all ones, HI = src_a as sampled, div_by_zero=1 in the done cycle.
- div_by_zero is cleared to 0 on every done pulse that is not a divide-by-zero.
- start while busy=1: ignored. No queueing.
- mthi/mtlo while idle:
  - The write takes effect at the edge.
  - Asserting both writes wdata to both registers.
  - start in the same cycle is also accepted; the later commit overwrites.
- mthi/mtlo while busy: ignored. Committed registers change only in FIX.
- hi_out/lo_out stay at their committed values throughout RUN. The working registers are internal.
- Operands are never re-read after E0. Changes on src_a/src_b/op during busy have no effect.

Decomposition:
- Package hilo_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum IDLE/RUN/FIX
- One sub-module, hilo_iter_core, holds the WIDTH-step shift-add / restoring-divide datapath:
  - inputs: magnitudes, is_div, step enable
  - outputs: raw hi/lo magnitudes
- The top level holds the FSM, sign handling, the HI/LO registers and MT writes.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF → busy high for 33 cycles; done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 * 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, div_by_zero=0.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064, div_by_zero=1 in the done cycle. Also DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Idle mthi+mtlo, wdata=0x12345678 → both regs 0x12345678 next cycle. During a MULTU 2*3: mthi with 0xDEADBEEF plus a second start → both ignored; final HI=0, LO=6.
- Assert reset in RUN cycle 10 of DIVU → hi_out/lo_out=0, busy=0, no done pulse. A fresh DIVU 9/4 afterwards → LO=2, HI=1 at standard latency.
